// File: rtl/ser_link_tx.sv
// Serial frame transmitter: start bit, WIDTH payload bits LSB first, optional
// even-parity bit, stop bit, with each level held for DIV clock cycles.
module ser_link_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             line_out,
    output logic             busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shift;
    logic             r_par;
    logic             r_line;
    logic             r_busy;
    logic             r_init;

    logic             w_accept;
    logic             w_tc;
    logic             w_last;
    logic [2:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_line_nxt;

    // r_init holds in_ready low until the first edge after reset release.
    assign in_ready = r_init && (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_tc     = (r_cnt == CW'(DIV - 1));
    assign w_last   = (r_idx == IW'(WIDTH - 1));
    assign line_out = r_line;
    assign busy     = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)         w_state_nxt = S_START;
            S_START:  if (w_tc)             w_state_nxt = S_DATA;
            S_DATA:   if (w_tc && w_last)   w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
            S_PARITY: if (w_tc)             w_state_nxt = S_STOP;
            S_STOP:   if (w_tc)             w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept) begin
            w_shift_nxt = in_data;
        end else if ((r_state == S_DATA) && w_tc) begin
            w_shift_nxt = r_shift >> 1;
        end
    end

    // Line level is taken from next state so it changes on the same edge as the FSM.
    always_comb begin
        w_line_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_line_nxt = 1'b0;
            S_DATA:   w_line_nxt = w_shift_nxt[0];
            S_PARITY: w_line_nxt = r_par;
            default:  w_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_line  <= 1'b1;
            r_busy  <= 1'b0;
            r_init  <= 1'b0;
        end else begin
            r_init  <= 1'b1;
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_line  <= w_line_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);

            if (w_accept || w_tc) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_accept) begin
                r_idx <= '0;
                r_par <= ^in_data;
            end else if ((r_state == S_DATA) && w_tc) begin
                r_idx <= w_last ? '0 : r_idx + IW'(1);
            end
        end
    end

endmodule

// File: doc/ser_link_tx.md
SER_LINK_TX -- requirements
Module: ser_link_tx

Interface
REQ-001 Parameter WIDTH, default 8: payload bits per frame; legal range 1..32.
REQ-002 Parameter DIV, default 4: clock cycles per serial bit; legal range 2..256.
REQ-003 Parameter PARITY_EN, default 1: 1 appends an even-parity bit, 0 omits it.
REQ-004 Port clk, input, 1: single clock; every flop samples on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port in_data, input, WIDTH: payload word; sampled on accept.
REQ-007 Port in_valid, input, 1: in_data is valid.
REQ-008 Port in_ready, output, 1: block can accept a word this cycle.
REQ-009 Port line_out, output, 1: serial line, registered; idles high.
REQ-010 Port busy, output, 1: a frame is in progress, registered.

Function
REQ-011 Accept occurs on a rising clk edge with in_valid=1 and in_ready=1; in_data is captured into an internal shift register on that edge.
REQ-012 in_ready is 1 only in IDLE; it is combinational from state only and never depends on in_valid.
REQ-013 The state machine has states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START on accept; all other transitions occur when the bit counter reaches DIV-1.
REQ-015 Transitions on bit-counter terminal count: START -> DATA; DATA -> PARITY after bit WIDTH-1 when PARITY_EN=1, otherwise DATA -> STOP; PARITY -> STOP; STOP -> IDLE.
REQ-016 Bit counter: counts 0..DIV-1; clears on accept and on every state change; width is ceil(log2(DIV)).
REQ-017 Line levels by state: START drives line_out=0; DATA drives payload LSB first; PARITY drives the XOR of all WIDTH payload bits (even parity); STOP and IDLE drive 1.
REQ-018 Data index: counts 0..WIDTH-1 and advances at each DATA bit end; the shift register shifts right by one at the same time.
REQ-019 Each line level, including STOP, is held for exactly DIV cycles.
REQ-020 Latency: line_out goes 0 on the first edge after accept, because it is registered from next-state.
REQ-021 Frame length is DIV*(WIDTH+2+PARITY_EN) cycles.
REQ-022 A new word can be accepted on the first cycle back in IDLE; there is no extra idle gap.
REQ-023 busy is 1 from the edge after accept until the edge that returns the state to IDLE.
REQ-024 in_valid in non-IDLE states is ignored: no capture, no state effect; a held request is accepted on return to IDLE.
REQ-025 in_data changes after accept do not affect the frame in flight.
REQ-026 Parity is computed from the captured word, not from live in_data.

Reset
REQ-027 While rst_n=0: state=IDLE, line_out=1, busy=0, in_ready=0, counters and shift register=0.
REQ-028 in_ready rises on the first clk edge after rst_n deasserts; no accept can occur before then.
REQ-029 Reset asserted mid-frame aborts the frame immediately, with no glitch to 0 on line_out, and no partial frame resumes after release.

Verification
REQ-030 Single frame, WIDTH=8, DIV=4, PARITY_EN=1, in_data=0xA5 -> line_out = 0 then 1,0,1,0,0,1,0,1 then parity 0 then 1, each level held 4 cycles, 44 cycles total; busy high for exactly 44 cycles.
REQ-031 Back-to-back: in_valid held high with 0x01 then 0xFF -> second start bit begins on the edge immediately after the first stop bit ends; the 0xFF parity bit is 0 and the 0x01 parity bit is 1.
REQ-032 PARITY_EN=0, in_data=0x80 -> 40-cycle frame with no parity slot; the last data bit is 1 and is followed directly by stop.
REQ-033 in_valid pulsed and in_data toggled during busy -> no extra frame is sent and the serialized bits match the originally accepted word.
REQ-034 rst_n pulled low during data bit 3 -> line_out=1 and busy=0 asynchronously; after release, in_ready=1 on the next edge and the next accepted word is framed correctly.
REQ-035 DIV=2, WIDTH=1, in_data=1 -> frame 0,1,1,1 with each level held 2 cycles, 8 cycles total.
